// File: rtl/am2302_axil_slave_if.sv
// AXI4-Lite bundle between a bus master and the AM2302 register block.
// Clock and reset stay outside so the bundle only carries handshake traffic.
interface am2302_axil_slave_if #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4
);
   logic [C_S_AXI_ADDR_WIDTH-1:0]     awaddr;
   logic [2:0]                        awprot;
   logic                              awvalid;
   logic                              awready;
   logic [C_S_AXI_DATA_WIDTH-1:0]     wdata;
   logic [(C_S_AXI_DATA_WIDTH/8)-1:0] wstrb;
   logic                              wvalid;
   logic                              wready;
   logic [1:0]                        bresp;
   logic                              bvalid;
   logic                              bready;
   logic [C_S_AXI_ADDR_WIDTH-1:0]     araddr;
   logic [2:0]                        arprot;
   logic                              arvalid;
   logic                              arready;
   logic [C_S_AXI_DATA_WIDTH-1:0]     rdata;
   logic [1:0]                        rresp;
   logic                              rvalid;
   logic                              rready;

   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      output araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      input  araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/am2302_axil_slave.sv
// AXI4-Lite register block (CTRL/STATUS/DATA/PERIOD) bridging software to the
// AM2302 single-wire engine via start pulse, auto level and sticky status flags.
//
// write channel          | read channel
// state  | meaning       | state  | meaning
// W_IDLE | wait aw+w     | R_IDLE | wait ar
// W_ADDR | aw/wready,wr  | R_ADDR | arready, capture rdata
// W_RESP | bvalid held   | R_DATA | rvalid held until rready
module am2302_axil_slave #(
   parameter int          C_S_AXI_DATA_WIDTH = 32,
   parameter int          C_S_AXI_ADDR_WIDTH = 4,
   parameter logic [31:0] PERIOD_RESET       = 32'd2_000_000
) (
   input  logic                      s00_axi_aclk,
   input  logic                      s00_axi_areset,
   am2302_axil_slave_if.slave        s00_axi,
   output logic                      start_o,
   output logic                      auto_en_o,
   output logic [31:0]               period_o,
   input  logic                      busy_i,
   input  logic                      sample_valid_i,
   input  logic [31:0]               sample_i,
   input  logic                      crc_err_i,
   input  logic                      timeout_i
);

   typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

   localparam logic [1:0] SEL_CTRL   = 2'd0;
   localparam logic [1:0] SEL_STATUS = 2'd1;
   localparam logic [1:0] SEL_DATA   = 2'd2;
   localparam logic [1:0] SEL_PERIOD = 2'd3;

   w_state_t w_state, w_next;
   r_state_t r_state, r_next;

   logic                          wr_en;
   logic [1:0]                    wr_sel;
   logic                          start_wr;
   logic [3:0]                    st_q;
   logic [3:0]                    st_set;
   logic [3:0]                    st_clr;
   logic                          auto_q;
   logic [31:0]                   period_q;
   logic [31:0]                   data_q;
   logic [1:0]                    bresp_q;
   logic [C_S_AXI_ADDR_WIDTH-1:0] ar_addr_q;
   logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
   logic [C_S_AXI_DATA_WIDTH-1:0] rd_mux;
   logic                          unused_bits;

   always_ff @(posedge s00_axi_aclk) begin
      if (s00_axi_areset) begin
         w_state <= W_IDLE;
         r_state <= R_IDLE;
      end else begin
         w_state <= w_next;
         r_state <= r_next;
      end
   end

   always_comb begin
      w_next          = w_state;
      s00_axi.awready = 1'b0;
      s00_axi.wready  = 1'b0;
      s00_axi.bvalid  = 1'b0;
      case (w_state)
         W_IDLE: if (s00_axi.awvalid && s00_axi.wvalid) w_next = W_ADDR;
         W_ADDR: begin
            s00_axi.awready = 1'b1;
            s00_axi.wready  = 1'b1;
            w_next          = W_RESP;
         end
         W_RESP: begin
            s00_axi.bvalid = 1'b1;
            if (s00_axi.bready) w_next = W_IDLE;
         end
         default: w_next = W_IDLE;
      endcase
   end

   always_comb begin
      r_next          = r_state;
      s00_axi.arready = 1'b0;
      s00_axi.rvalid  = 1'b0;
      case (r_state)
         R_IDLE: if (s00_axi.arvalid) r_next = R_ADDR;
         R_ADDR: begin
            s00_axi.arready = 1'b1;
            r_next          = R_DATA;
         end
         R_DATA: begin
            s00_axi.rvalid = 1'b1;
            if (s00_axi.rready) r_next = R_IDLE;
         end
         default: r_next = R_IDLE;
      endcase
   end

   // status bits {overrun, timeout, crc_err, valid}; a set in the same cycle beats a W1C
   always_comb begin
      wr_en    = (w_state == W_ADDR);
      wr_sel   = s00_axi.awaddr[3:2];
      start_wr = wr_en && (wr_sel == SEL_CTRL) && s00_axi.wstrb[0] && s00_axi.wdata[0];
      st_set   = {start_wr && busy_i, timeout_i, crc_err_i, sample_valid_i};
      st_clr   = 4'b0;
      if (wr_en && (wr_sel == SEL_STATUS) && s00_axi.wstrb[0])
         st_clr = s00_axi.wdata[4:1];
   end

   always_ff @(posedge s00_axi_aclk) begin
      if (s00_axi_areset) begin
         start_o  <= 1'b0;
         auto_q   <= 1'b0;
         period_q <= PERIOD_RESET;
         st_q     <= 4'b0;
         data_q   <= 32'b0;
         bresp_q  <= 2'b00;
      end else begin
         start_o <= start_wr && !busy_i;
         st_q    <= (st_q & ~st_clr) | st_set;
         if (sample_valid_i)
            data_q <= sample_i;
         if (wr_en) begin
            bresp_q <= (wr_sel == SEL_DATA) ? 2'b10 : 2'b00;
            if ((wr_sel == SEL_CTRL) && s00_axi.wstrb[0])
               auto_q <= s00_axi.wdata[1];
            if (wr_sel == SEL_PERIOD) begin
               for (int i = 0; i < 4; i++)
                  if (s00_axi.wstrb[i])
                     period_q[8*i +: 8] <= s00_axi.wdata[8*i +: 8];
            end
         end
      end
   end

   always_comb begin
      rd_mux = '0;
      case (ar_addr_q[3:2])
         SEL_CTRL:   rd_mux = {30'b0, auto_q, 1'b0};
         SEL_STATUS: rd_mux = {27'b0, st_q, busy_i};
         SEL_DATA:   rd_mux = data_q;
         SEL_PERIOD: rd_mux = period_q;
         default:    rd_mux = '0;
      endcase
   end

   // rdata is frozen at the arready edge so a same-cycle sample update shows up only on the next read
   always_ff @(posedge s00_axi_aclk) begin
      if (s00_axi_areset) begin
         ar_addr_q <= '0;
         rdata_q   <= '0;
      end else begin
         if ((r_state == R_IDLE) && s00_axi.arvalid)
            ar_addr_q <= s00_axi.araddr;
         if (r_state == R_ADDR)
            rdata_q <= rd_mux;
      end
   end

   assign s00_axi.rdata = rdata_q;
   assign s00_axi.rresp = 2'b00;
   assign s00_axi.bresp = bresp_q;
   assign auto_en_o     = auto_q;
   assign period_o      = period_q;
   assign unused_bits   = ^{s00_axi.awprot, s00_axi.arprot, s00_axi.awaddr[1:0], ar_addr_q[1:0]};

endmodule
